// File: rtl/fp_pkg.sv
// Shared single-precision float definitions for the dot-product datapath.
package fp_pkg;

  localparam int FP_XLEN = 32;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // Ceiling log2 for elaboration-time sizing (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/FloatingAddition.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Denormal operands are treated as zero and underflowing results flush to zero.
module FloatingAddition
  import fp_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  fp32_t              w_a;
  fp32_t              w_b;
  fp32_t              w_big;
  fp32_t              w_sml;
  logic [7:0]         w_diff;
  logic [27:0]        w_m_big;
  logic [27:0]        w_m_sml;
  logic [27:0]        w_shifted;
  logic               w_lost;
  logic [27:0]        w_sum;
  logic [26:0]        w_norm;
  logic [4:0]         w_lz;
  logic               w_found;
  logic signed [9:0]  w_exp;
  logic               w_inc;
  logic [24:0]        w_rnd;
  logic [22:0]        w_frac;
  logic               w_a_nan;
  logic               w_b_nan;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_zero;
  logic               w_b_zero;

  assign w_a = i_a;
  assign w_b = i_b;

  // Align the smaller magnitude, add/subtract, renormalise, round, select specials.
  always_comb begin
    if ({w_b.exp, w_b.frac} > {w_a.exp, w_a.frac}) begin
      w_big = w_b;
      w_sml = w_a;
    end else begin
      w_big = w_a;
      w_sml = w_b;
    end
    w_diff = w_big.exp - w_sml.exp;
    // Layout: carry | hidden | 23 fraction | guard | round | sticky
    w_m_big = {1'b0, 1'b1, w_big.frac, 3'b000};
    w_m_sml = {1'b0, 1'b1, w_sml.frac, 3'b000};
    if (w_diff > 8'd27) begin
      w_shifted = '0;
      w_lost    = 1'b1;
    end else begin
      w_shifted = w_m_sml >> w_diff;
      w_lost    = |(w_m_sml & ~(28'hFFF_FFFF << w_diff));
    end
    w_shifted = w_shifted | {27'b0, w_lost};

    if (w_big.sign == w_sml.sign) w_sum = w_m_big + w_shifted;
    else                          w_sum = w_m_big - w_shifted;

    w_exp   = $signed({2'b00, w_big.exp});
    w_lz    = '0;
    w_found = 1'b0;
    w_norm  = '0;
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = w_exp + 10'sd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!w_found) begin
          if (w_sum[i]) w_found = 1'b1;
          else          w_lz    = w_lz + 5'd1;
        end
      end
      w_norm = w_sum[26:0] << w_lz;
      w_exp  = w_exp - $signed({5'b00000, w_lz});
    end

    w_inc = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd = {1'b0, w_norm[26:3]} + {24'b0, w_inc};
    if (w_rnd[24]) begin
      w_exp  = w_exp + 10'sd1;
      w_frac = w_rnd[23:1];
    end else begin
      w_frac = w_rnd[22:0];
    end

    w_a_nan  = (w_a.exp == 8'hFF) && (w_a.frac != '0);
    w_b_nan  = (w_b.exp == 8'hFF) && (w_b.frac != '0);
    w_a_inf  = (w_a.exp == 8'hFF) && (w_a.frac == '0);
    w_b_inf  = (w_b.exp == 8'hFF) && (w_b.frac == '0);
    w_a_zero = (w_a.exp == 8'h00);
    w_b_zero = (w_b.exp == 8'h00);

    o_y = {w_big.sign, w_exp[7:0], w_frac};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b.sign))) begin
      o_y = FP_QNAN;
    end else if (w_a_inf) begin
      o_y = i_a;
    end else if (w_b_inf) begin
      o_y = i_b;
    end else if (w_a_zero && w_b_zero) begin
      o_y = {w_a.sign & w_b.sign, 31'b0};
    end else if (w_a_zero) begin
      o_y = i_b;
    end else if (w_b_zero) begin
      o_y = i_a;
    end else if (w_sum == '0) begin
      // Exact cancellation yields +0 under round-to-nearest.
      o_y = FP_ZERO;
    end else if (w_exp >= 10'sd255) begin
      o_y = {w_big.sign, 8'hFF, 23'b0};
    end else if (w_exp <= 10'sd0) begin
      o_y = {w_big.sign, 31'b0};
    end
  end

endmodule

// File: rtl/FloatingMultiplication.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Denormal operands are treated as zero and underflowing results flush to zero.
module FloatingMultiplication
  import fp_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  fp32_t              w_a;
  fp32_t              w_b;
  logic               w_sign;
  logic [47:0]        w_prod;
  logic signed [9:0]  w_exp;
  logic [22:0]        w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic [23:0]        w_rnd;
  logic               w_a_nan;
  logic               w_b_nan;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_zero;
  logic               w_b_zero;

  assign w_a = i_a;
  assign w_b = i_b;

  // Mantissa product, normalisation, rounding and special-case selection.
  always_comb begin
    w_sign   = w_a.sign ^ w_b.sign;
    w_prod   = {24'b0, 1'b1, w_a.frac} * {24'b0, 1'b1, w_b.frac};
    w_exp    = $signed({2'b00, w_a.exp}) + $signed({2'b00, w_b.exp}) - 10'sd127;
    w_mant   = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (w_prod[47]) begin
      w_mant   = w_prod[46:24];
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
      w_exp    = w_exp + 10'sd1;
    end else begin
      w_mant   = w_prod[45:23];
      w_guard  = w_prod[22];
      w_sticky = |w_prod[21:0];
    end
    w_rnd = {1'b0, w_mant} + {23'b0, (w_guard & (w_sticky | w_mant[0]))};
    // Rounding carry out of the mantissa leaves it at 1.0 of the next binade.
    if (w_rnd[23]) w_exp = w_exp + 10'sd1;

    w_a_nan  = (w_a.exp == 8'hFF) && (w_a.frac != '0);
    w_b_nan  = (w_b.exp == 8'hFF) && (w_b.frac != '0);
    w_a_inf  = (w_a.exp == 8'hFF) && (w_a.frac == '0);
    w_b_inf  = (w_b.exp == 8'hFF) && (w_b.frac == '0);
    w_a_zero = (w_a.exp == 8'h00);
    w_b_zero = (w_b.exp == 8'h00);

    o_y = {w_sign, w_exp[7:0], w_rnd[22:0]};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      o_y = FP_QNAN;
    end else if (w_a_inf || w_b_inf) begin
      o_y = {w_sign, 8'hFF, 23'b0};
    end else if (w_a_zero || w_b_zero) begin
      o_y = {w_sign, 31'b0};
    end else if (w_exp >= 10'sd255) begin
      o_y = {w_sign, 8'hFF, 23'b0};
    end else if (w_exp <= 10'sd0) begin
      o_y = {w_sign, 31'b0};
    end
  end

endmodule

// File: rtl/fp_add_tree_level.sv
// One registered adder-tree level: N operands in, N/2 pairwise sums out.
// Operands (2k, 2k+1) feed sum k; valid and first tag travel with the data.
module fp_add_tree_level
  import fp_pkg::*;
#(
  parameter int XLEN = FP_XLEN,
  parameter int N    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic                  i_first,
  input  logic [N*XLEN-1:0]     i_ops,
  output logic                  o_valid,
  output logic                  o_first,
  output logic [(N/2)*XLEN-1:0] o_sums
);

  logic [(N/2)*XLEN-1:0] w_sums;
  logic [(N/2)*XLEN-1:0] r_sums;
  logic                  r_valid;
  logic                  r_first;

  for (genvar k = 0; k < N/2; k++) begin : g_add
    FloatingAddition u_add (
      .i_a (i_ops[(2*k)*XLEN   +: XLEN]),
      .i_b (i_ops[(2*k+1)*XLEN +: XLEN]),
      .o_y (w_sums[k*XLEN      +: XLEN])
    );
  end

  // Level register; holds while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sums  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
    end else if (i_en) begin
      r_sums  <= w_sums;
      r_valid <= i_valid;
      r_first <= i_first;
    end
  end

  assign o_sums  = r_sums;
  assign o_valid = r_valid;
  assign o_first = r_first;

endmodule

// File: rtl/pipelined_dot_product_unit.sv
// LANES-wide single-precision dot product: registered multiply stage,
// log2(LANES) registered adder-tree levels, registered accumulator.
// The whole pipeline advances together whenever the output is free or taken.
module pipelined_dot_product_unit
  import fp_pkg::*;
#(
  parameter int XLEN  = FP_XLEN,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*XLEN-1:0] nums,
  input  logic [LANES*XLEN-1:0] weights,
  input  logic                  in_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result
);

  localparam int D     = clog2(LANES);
  // Tree nodes packed level after level: LANES products, LANES/2 sums, ..., 1.
  localparam int NODES = 2*LANES - 1;

  logic                  w_adv;
  logic [LANES*XLEN-1:0] w_prod;
  logic [LANES*XLEN-1:0] r_prod;
  logic                  r_s0_valid;
  logic                  r_s0_first;
  logic [NODES*XLEN-1:0] w_tree;
  logic [D:0]            w_lvl_valid;
  logic [D:0]            w_lvl_first;
  logic [XLEN-1:0]       w_tree_sum;
  logic [XLEN-1:0]       w_acc_sum;
  logic [XLEN-1:0]       r_acc;
  logic                  r_out_valid;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    FloatingMultiplication u_mul (
      .i_a (nums[i*XLEN    +: XLEN]),
      .i_b (weights[i*XLEN +: XLEN]),
      .o_y (w_prod[i*XLEN  +: XLEN])
    );
  end

  // S0: capture lane products; an idle input loads a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod     <= '0;
      r_s0_valid <= 1'b0;
      r_s0_first <= 1'b0;
    end else if (w_adv) begin
      r_prod     <= w_prod;
      r_s0_valid <= in_valid;
      r_s0_first <= in_first;
    end
  end

  assign w_tree[LANES*XLEN-1:0] = r_prod;
  assign w_lvl_valid[0]         = r_s0_valid;
  assign w_lvl_first[0]         = r_s0_first;

  for (genvar l = 1; l <= D; l++) begin : g_lvl
    localparam int N_IN    = LANES >> (l - 1);
    localparam int IN_OFF  = 2*LANES - 2*N_IN;
    localparam int OUT_OFF = 2*LANES - N_IN;

    fp_add_tree_level #(
      .XLEN (XLEN),
      .N    (N_IN)
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_valid (w_lvl_valid[l-1]),
      .i_first (w_lvl_first[l-1]),
      .i_ops   (w_tree[IN_OFF*XLEN +: N_IN*XLEN]),
      .o_valid (w_lvl_valid[l]),
      .o_first (w_lvl_first[l]),
      .o_sums  (w_tree[OUT_OFF*XLEN +: (N_IN/2)*XLEN])
    );
  end

  assign w_tree_sum = w_tree[(NODES-1)*XLEN +: XLEN];

  FloatingAddition u_acc_add (
    .i_a (r_acc),
    .i_b (w_tree_sum),
    .o_y (w_acc_sum)
  );

  // SA: restart or extend the running sum; bubbles leave the accumulator alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= FP_ZERO;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_lvl_valid[D];
      if (w_lvl_valid[D]) begin
        r_acc <= w_lvl_first[D] ? w_tree_sum : w_acc_sum;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_acc;

endmodule

// File: tb/tb_pipelined_dot_product_unit.sv
// Directed bench for pipelined_dot_product_unit: LANES=4 main instance plus
// LANES=8 and LANES=2 instances for latency/width checks.
module tb_pipelined_dot_product_unit;

  localparam logic [31:0] F0   = 32'h0000_0000;
  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F4   = 32'h4080_0000;
  localparam logic [31:0] F5   = 32'h40A0_0000;
  localparam logic [31:0] F6   = 32'h40C0_0000;
  localparam logic [31:0] F8   = 32'h4100_0000;
  localparam logic [31:0] F10  = 32'h4120_0000;
  localparam logic [31:0] F15  = 32'h4170_0000;
  localparam logic [31:0] F20  = 32'h41A0_0000;
  localparam logic [31:0] F30  = 32'h41F0_0000;
  localparam logic [31:0] FH   = 32'h3F00_0000;  // 0.5
  localparam logic [31:0] FQ   = 32'h3E80_0000;  // 0.25
  localparam logic [31:0] F1P5 = 32'h3FC0_0000;
  localparam logic [31:0] FM1  = 32'hBF80_0000;
  localparam logic [31:0] FM2  = 32'hC000_0000;
  localparam logic [31:0] FM10 = 32'hC120_0000;

  localparam logic [127:0] V1234 = {F4, F3, F2, F1};
  localparam logic [127:0] ONES4 = {F1, F1, F1, F1};

  typedef struct {
    logic [127:0] n;
    logic [127:0] w;
    logic         f;
    logic [31:0]  exp;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, in_first, out_valid, out_ready;
  logic [127:0] nums, weights;
  logic [31:0]  result;

  logic         in_valid8, in_ready8, in_first8, out_valid8, out_ready8;
  logic [255:0] nums8, weights8;
  logic [31:0]  result8;

  logic         in_valid2, in_ready2, in_first2, out_valid2, out_ready2;
  logic [63:0]  nums2, weights2;
  logic [31:0]  result2;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_dot_product_unit #(.XLEN(32), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .nums(nums), .weights(weights), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  pipelined_dot_product_unit #(.XLEN(32), .LANES(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .nums(nums8), .weights(weights8), .in_first(in_first8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8)
  );

  pipelined_dot_product_unit #(.XLEN(32), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .nums(nums2), .weights(weights2), .in_first(in_first2),
    .out_valid(out_valid2), .out_ready(out_ready2), .result(result2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One vector on the LANES=4 unit with out_ready=1: latency, value, single beat.
  task automatic send_and_check(input logic [127:0] n, input logic [127:0] w,
                                input logic f, input logic [31:0] exp_r, input string name);
    int cyc;
    @(negedge clk);
    check({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; nums = n; weights = w; in_first = f;
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, cyc, 32'd4);
    check({name, "_result"}, result, exp_r);
    @(negedge clk);
    check({name, "_single_beat"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[9];
    logic [31:0]  bp_vals[6];
    int           sent, recv, lat8, lat2;
    logic [31:0]  res8, res2;

    tbl[0] = '{n: V1234,                  w: ONES4,                  f: 1'b1, exp: F10};
    tbl[1] = '{n: {F3, F2, F1, F4},       w: {F0, F0, F0, F2},       f: 1'b1, exp: F8};
    tbl[2] = '{n: {F3, F2, F4, F1},       w: {F0, F0, F2, F0},       f: 1'b1, exp: F8};
    tbl[3] = '{n: {F3, F4, F2, F1},       w: {F0, F2, F0, F0},       f: 1'b1, exp: F8};
    tbl[4] = '{n: {F4, F3, F2, F1},       w: {F2, F0, F0, F0},       f: 1'b1, exp: F8};
    tbl[5] = '{n: {F3, FH, FM2, F1P5},    w: {FM1, F4, F1, F2},      f: 1'b1, exp: F0};
    tbl[6] = '{n: {F1, F8, FQ, FH},       w: {FM2, FH, F4, F4},      f: 1'b1, exp: F5};
    tbl[7] = '{n: V1234,                  w: ONES4,                  f: 1'b0, exp: F15};
    tbl[8] = '{n: V1234,                  w: {FM1, FM1, FM1, FM1},   f: 1'b1, exp: FM10};
    bp_vals[0] = F1; bp_vals[1] = F2; bp_vals[2] = F3;
    bp_vals[3] = F4; bp_vals[4] = F5; bp_vals[5] = F6;

    rst = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; nums = '0; weights = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_first8 = 1'b0; nums8 = '0; weights8 = '0; out_ready8 = 1'b1;
    in_valid2 = 1'b0; in_first2 = 1'b0; nums2 = '0; weights2 = '0; out_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid8", {31'b0, out_valid8}, 32'd0);
    check("rst_out_valid2", {31'b0, out_valid2}, 32'd0);

    // Single vectors: sum, per-lane wiring, cancellation, mixed signs, accumulate.
    for (int i = 0; i < 9; i++) begin
      send_and_check(tbl[i].n, tbl[i].w, tbl[i].f, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Back-to-back accumulation: 10, 20, 30 on consecutive cycles.
    @(negedge clk);
    in_valid = 1'b1; nums = V1234; weights = ONES4; in_first = 1'b1;
    @(negedge clk);
    in_first = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("acc0_valid", {31'b0, out_valid}, 32'd1);
    check("acc0_result", result, F10);
    @(negedge clk);
    check("acc1_valid", {31'b0, out_valid}, 32'd1);
    check("acc1_result", result, F20);
    @(negedge clk);
    check("acc2_valid", {31'b0, out_valid}, 32'd1);
    check("acc2_result", result, F30);
    @(negedge clk);
    check("acc_done", {31'b0, out_valid}, 32'd0);

    // Back-pressure: six vectors, output stalled for five cycles.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 9);
      if (sent < 6) begin
        in_valid = 1'b1; nums = {96'b0, bp_vals[sent]}; weights = ONES4; in_first = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 6) begin
        check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        check("bp_accepted_before_stall", sent, 32'd4);
      end
      if (out_valid) begin
        if (recv < 6) check($sformatf("bp_result%0d", recv), result, bp_vals[recv]);
        else          check("bp_no_extra_beat", {31'b0, out_valid}, 32'd0);
        if (out_ready) recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("bp_beats", recv, 32'd6);
    check("bp_sent", sent, 32'd6);
    in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;

    // Reset with two vectors in flight; acc currently holds 6.0.
    @(negedge clk);
    in_valid = 1'b1; nums = V1234; weights = ONES4; in_first = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_flushed%0d", c), {31'b0, out_valid}, 32'd0);
    end
    send_and_check(V1234, ONES4, 1'b0, F10, "post_rst");

    // LANES=8 and LANES=2 builds with all-ones vectors.
    @(negedge clk);
    in_valid8 = 1'b1; nums8 = {8{F1}}; weights8 = {8{F1}}; in_first8 = 1'b1;
    in_valid2 = 1'b1; nums2 = {2{F1}}; weights2 = {2{F1}}; in_first2 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0; in_valid2 = 1'b0;
    lat8 = 0; lat2 = 0; res8 = '0; res2 = '0;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid8 && lat8 == 0) begin lat8 = c; res8 = result8; end
      if (out_valid2 && lat2 == 0) begin lat2 = c; res2 = result2; end
      if (lat8 != 0 && lat2 != 0) break;
      @(negedge clk);
    end
    check("lanes8_latency", lat8, 32'd5);
    check("lanes8_result", res8, F8);
    check("lanes2_latency", lat2, 32'd3);
    check("lanes2_result", res2, F2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
